// File: rtl/dtw_pkg.sv
// ---------------------------------------------------------------------------
// dtw_pkg
// Shared definitions for the DTW result arbiter: the serialiser FSM state
// encoding, the packet shape (three beats per record), the core-id field width
// and a helper that builds the header beat (B0) of each packet.
// ---------------------------------------------------------------------------
package dtw_pkg;

  localparam int BEATS_PER_REC = 3;
  localparam int CORE_ID_W     = 8;
  localparam int TDATA_W       = 32;

  // One idle/grant state plus one state per beat of the packet.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_B2   = 2'd3
  } arb_state_e;

  // Header beat layout: {qid (zero-extended to 16), 8'h00, core id}.
  function automatic logic [TDATA_W-1:0] b0_word(input logic [15:0] qid,
                                                 input logic [CORE_ID_W-1:0] core_id);
    return {qid, 8'h00, core_id};
  endfunction

endpackage

// File: rtl/dtw_result_fifo.sv
// ---------------------------------------------------------------------------
// dtw_result_fifo
// Per-core synchronous record FIFO with occupancy count, registered full flag
// and a sticky overflow flag.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous flush: empties the FIFO, clears ovf, drops a write
//   wr_en       write strobe; accepted only when count < DEPTH
//   wr_data     record to store
//   rd_en       pop strobe; ignored when empty
//   rd_data     head of the FIFO (show-ahead, valid while count != 0)
//   count       number of stored records (0..DEPTH)
//   full        registered, high while count == DEPTH
//   ovf         sticky, set when a write arrives while count == DEPTH
// ---------------------------------------------------------------------------
module dtw_result_fifo #(
  parameter  int W     = 80,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             ovf
);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             wr_ok;
  logic             rd_ok;
  logic             at_depth;

  // The full decision uses the count before this edge, so a write to a full
  // FIFO is dropped even when the head is popped in the same cycle.
  assign at_depth = (count == CNT_W'(DEPTH));
  assign wr_ok    = wr_en && !clr && !at_depth;
  assign rd_ok    = rd_en && !clr && (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count + 1'b1;
        2'b01:   count_d = count - 1'b1;
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && at_depth) ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dtw_result_axis_arbiter.sv
// ---------------------------------------------------------------------------
// dtw_result_axis_arbiter
// Buffers {minval, position, qid} result records from N_CORES dtw_core
// instances in per-core FIFOs, picks them round-robin and serialises each one
// onto the M00_AXIS master stream as a 3-beat packet:
//   beat 0: {zext16(qid), 8'h00, core_id[7:0]}
//   beat 1: zext32(minval)
//   beat 2: zext32(position), TLAST=1
//
// Ports
//   M_AXIS_ACLK, M_AXIS_ARESETN  clock, asynchronous active-low reset
//   clr              sync clear: flush all FIFOs and ovf; in-flight packet completes
//   sink_fifo_wren   per-core write strobe
//   sink_minval      core k at [k*VAL_W +: VAL_W]
//   sink_position    core k at [k*POS_W +: POS_W]
//   sink_qid         core k at [k*QID_W +: QID_W]
//   sink_fifo_full   per-core FIFO full (registered)
//   ovf              per-core sticky drop flag
//   busy             packet in flight or any FIFO non-empty
//   M_AXIS_*         AXI4-Stream master (TSTRB tied to all ones)
//   dbg_state        current serialiser state (arb_state_e encoding)
//
// Handshake: a beat transfers on a rising edge where TVALID && TREADY. Once
// TVALID is raised, TVALID, TDATA and TLAST hold until that transfer; TVALID
// never depends combinationally on TREADY.
// ---------------------------------------------------------------------------
module dtw_result_axis_arbiter
  import dtw_pkg::*;
#(
  parameter int N_CORES              = 4,
  parameter int FIFO_DEPTH           = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int VAL_W                = 32,
  parameter int POS_W                = 32,
  parameter int QID_W                = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              clr,
  input  logic [N_CORES-1:0]                sink_fifo_wren,
  input  logic [N_CORES*VAL_W-1:0]          sink_minval,
  input  logic [N_CORES*POS_W-1:0]          sink_position,
  input  logic [N_CORES*QID_W-1:0]          sink_qid,
  output logic [N_CORES-1:0]                sink_fifo_full,
  output logic [N_CORES-1:0]                ovf,
  output logic                              busy,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [1:0]                        dbg_state
);

  localparam int REC_W = VAL_W + POS_W + QID_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  // ---- elaboration-time parameter legality --------------------------------
  if (N_CORES < 1 || N_CORES > 256) begin : g_bad_ncores
    $error("N_CORES must be in 1..256");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (C_M_AXIS_TDATA_WIDTH != TDATA_W) begin : g_bad_tdata
    $error("C_M_AXIS_TDATA_WIDTH must be 32");
  end
  if (VAL_W < 1 || VAL_W > 32 || POS_W < 1 || POS_W > 32 || QID_W < 1 || QID_W > 16)
  begin : g_bad_fields
    $error("field widths out of range (VAL_W/POS_W <= 32, QID_W <= 16)");
  end
  if (BEATS_PER_REC != 3) begin : g_bad_beats
    $error("serialiser is built for exactly three beats per record");
  end

  logic                clk;
  logic                rst_n;
  assign clk   = M_AXIS_ACLK;
  assign rst_n = M_AXIS_ARESETN;

  // ---- per-core FIFOs -----------------------------------------------------
  logic [REC_W-1:0]    rd_data  [N_CORES];
  logic [CNT_W-1:0]    count    [N_CORES];
  logic [N_CORES-1:0]  nonempty;
  logic [N_CORES-1:0]  pop;

  for (genvar k = 0; k < N_CORES; k++) begin : g_fifo
    dtw_result_fifo #(
      .W     (REC_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .wr_en   (sink_fifo_wren[k]),
      .wr_data ({sink_qid[k*QID_W +: QID_W],
                 sink_position[k*POS_W +: POS_W],
                 sink_minval[k*VAL_W +: VAL_W]}),
      .rd_en   (pop[k]),
      .rd_data (rd_data[k]),
      .count   (count[k]),
      .full    (sink_fifo_full[k]),
      .ovf     (ovf[k])
    );
    assign nonempty[k] = (count[k] != '0);
  end

  // ---- round-robin search -------------------------------------------------
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_valid;

  // First non-empty channel at or above rr_ptr, wrapping modulo N_CORES.
  always_comb begin
    int j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      j = (int'(rr_ptr) + i) % N_CORES;
      if (!gnt_valid && nonempty[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(j);
      end
    end
  end

  // ---- serialiser FSM -----------------------------------------------------
  arb_state_e          state_q;
  arb_state_e          state_d;
  logic                grant_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // No grant during clr: the FIFO contents are being discarded at this edge.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid && !clr) begin
          grant_fire = 1'b1;
          state_d    = ST_B0;
        end
      end
      ST_B0:   if (M_AXIS_TREADY) state_d = ST_B1;
      ST_B1:   if (M_AXIS_TREADY) state_d = ST_B2;
      ST_B2:   if (M_AXIS_TREADY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    if (grant_fire) pop[gnt_idx] = 1'b1;
  end

  // ---- output register (record + source core) ----------------------------
  logic [REC_W-1:0]     out_rec;
  logic [CORE_ID_W-1:0] out_core;
  logic [VAL_W-1:0]     out_minval;
  logic [POS_W-1:0]     out_pos;
  logic [QID_W-1:0]     out_qid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rec  <= '0;
      out_core <= '0;
      rr_ptr   <= '0;
    end else if (grant_fire) begin
      out_rec  <= rd_data[gnt_idx];
      out_core <= CORE_ID_W'(gnt_idx);
      if (int'(gnt_idx) == N_CORES - 1) rr_ptr <= '0;
      else                              rr_ptr <= gnt_idx + 1'b1;
    end
  end

  assign out_minval = out_rec[VAL_W-1:0];
  assign out_pos    = out_rec[VAL_W +: POS_W];
  assign out_qid    = out_rec[VAL_W+POS_W +: QID_W];

  // ---- stream outputs -----------------------------------------------------
  // TDATA is a pure function of registered state, so it is stable while stalled.
  logic [TDATA_W-1:0] tdata;

  always_comb begin
    tdata = '0;
    case (state_q)
      ST_B0:   tdata = b0_word(16'(out_qid), out_core);
      ST_B1:   tdata = 32'(out_minval);
      ST_B2:   tdata = 32'(out_pos);
      default: tdata = '0;
    endcase
  end

  assign M_AXIS_TDATA  = tdata;
  assign M_AXIS_TVALID = (state_q != ST_IDLE);
  assign M_AXIS_TLAST  = (state_q == ST_B2);
  assign M_AXIS_TSTRB  = '1;
  assign busy          = (state_q != ST_IDLE) || (|nonempty);
  assign dbg_state     = state_q;

endmodule
